// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war computer opponent.
package tow_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    COOLDOWN = 2'd2
  } player_state_t;

  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 10'h001;

  // x^10 + x^7 + 1 Fibonacci step; all-zero state is unreachable from a nonzero seed.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit maximal-length LFSR that steps only when advance is high.
module lfsr10
  import tow_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (advance) q_d = lfsr_step(q_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) q_q <= SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/computer_player.sv
// Automated right-side tug-of-war player: paced, pseudo-random single-cycle key presses.
//   state    | meaning
//   IDLE     | waiting for a tick; tick with lfsr < difficulty presses
//   PRESS    | press output high for exactly one cycle
//   COOLDOWN | next tick is consumed unevaluated, guaranteeing a release
module computer_player
  import tow_pkg::*;
#(
  parameter int                TICK_DIV = 4,
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              win,
  input  logic              enable,
  input  logic [LFSR_W-1:0] difficulty,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  player_state_t    state_q;
  player_state_t    state_d;
  logic             tick;
  logic             hit;

  assign tick = enable && (cnt_q == CNT_LAST);
  assign hit  = (lfsr_q < difficulty);

  always_comb begin
    cnt_d = cnt_q;
    if (win)                  cnt_d = '0;
    else if (!enable)         cnt_d = cnt_q;
    else if (cnt_q == CNT_LAST) cnt_d = '0;
    else                      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // The random source keeps running across rounds so successive rounds differ.
  lfsr10 #(.SEED(SEED)) u_lfsr (
    .Clock   (Clock),
    .Reset   (Reset),
    .advance (tick),
    .q       (lfsr_q)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable || win) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (tick && hit) state_d = PRESS;
        PRESS:    state_d = COOLDOWN;
        COOLDOWN: if (tick) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    press = (state_q == PRESS);
  end

endmodule
